stereo_matrix_gain: RTL and testbench
=====================================

Name: stereo_matrix_gain

Overview:
- Parametrised stereo matrix front end of the FM stereo modulator.
- Accepts one LEFT/RIGHT sample pair per handshake and forms saturated L+R and L−R.
- Scales each path by an unsigned gain k/2^FRAC using two serial shift-add multipliers, with selectable rounding and output saturation.
- Feeds the L+R and L−R interpolators; replaces the fixed 18-bit, 4-bit-gain, edge-triggered mixer with a clean valid/ready, fully synchronous design.

Parameters:
- DW, 18: signed sample width of inputs and outputs.
- KW, 4: unsigned gain width (Ks, Kd).
- FRAC, 3: gain fractional bits; gain = k / 2^FRAC.
- ROUND, 1: 1 = round half toward +inf before the shift; 0 = truncate (floor).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  sample pair present.
- in_ready  out  1  block can accept a pair; high only in IDLE.
- left  in  DW  signed left sample.
- right  in  DW  signed right sample.
- ks  in  KW  unsigned L+R gain, sampled at accept.
- kd  in  KW  unsigned L−R gain, sampled at accept.
- out_valid  out  1  one-cycle pulse; lpr/lmr/sat flags valid.
- lpr  out  DW  signed scaled L+R; held until next out_valid.
- lmr  out  DW  signed scaled L−R; held until next out_valid.
- sat_lpr  out  1  L+R saturated (mix or output stage); valid with out_valid.
- sat_lmr  out  1  L−R saturated; valid with out_valid.

Behaviour:
- Reset is synchronous, active-high, clock `clock`. Reset values:
  - lpr = lmr = 0; out_valid = sat_lpr = sat_lmr = 0.
  - in_ready = 1; state = IDLE; bit counter = 0.
- Reset mid-operation aborts the sample; no out_valid for it.
- Accept occurs when in_valid & in_ready at a rising edge (cycle T).
  - left, right, ks and kd are registered at accept.
  - in_valid while busy is ignored; no queueing.
- State machine IDLE → MIX → MULT → SCALE → IDLE:
  - IDLE: in_ready = 1; on accept go to MIX.
  - MIX (1 cycle):
    - sum = left + right and dif = left − right, computed at DW+1 bits.
    - Saturate to [−2^(DW−1), 2^(DW−1)−1] in both directions.
    - Record per-path mix-saturation bits; clear accumulators; go to MULT.
  - MULT (KW cycles):
    - Iteration i, LSB first: acc += k[i] ? (mixed <<< i) : 0.
    - Accumulators are signed, DW+KW+1 bits; no overflow possible.
    - After iteration KW−1 go to SCALE.
  - SCALE (1 cycle):
    - If ROUND=1 and FRAC>0, add 2^(FRAC−1) to acc.
    - Arithmetic right shift by FRAC.
    - Saturate to DW bits; register lpr/lmr.
    - sat_x = mix saturation OR output saturation.
    - Set out_valid = 1 for the next cycle; go to IDLE.
- Latency: out_valid is high in cycle T+KW+3 (T+7 at defaults).
  - in_ready is high in that same cycle, so a new accept there is legal.
  - Throughput: one pair per KW+3 cycles.
- k = 0 yields 0 on that path with no saturation.
- Gain > 1 (k > 2^FRAC) can overflow; this is clamped and flagged.
- The L+R and L−R paths always run in lockstep; out_valid is common to both.

Test Plan:
- Reset for 2 cycles → lpr = lmr = 0, out_valid = 0, in_ready = 1; state IDLE.
- left=1000, right=200, ks=kd=8, accept at T → out_valid only in T+7; lpr=1200, lmr=800; sat flags 0; in_ready low T+1..T+6.
- left=right=100000, ks=8, kd=8 → lpr=131071 with sat_lpr=1; lmr=0 with sat_lmr=0.
- left=−100000, right=100000, kd=15 → mix saturates to −131072; product >>3 = −245760; lmr=−131072, sat_lmr=1.
- Rounding: left=−4, right=0, ks=1 → lpr=0 when ROUND=1, −1 when ROUND=0. Also left=3, right=0, ks=3 → lpr=1.
- Assert reset during MULT → in_ready=1 next cycle, no out_valid. Hold in_valid high throughout → back-to-back samples every 7 cycles with correct results.

Source files
------------

// File: rtl/stereo_matrix_gain.sv
// Stereo matrix front end: forms saturated L+R / L-R and scales each path
// by k/2^FRAC with two serial shift-add multipliers running in lockstep.
module stereo_matrix_gain #(
  parameter int DW    = 18,
  parameter int KW    = 4,
  parameter int FRAC  = 3,
  parameter int ROUND = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] left,
  input  logic signed [DW-1:0] right,
  input  logic [KW-1:0]        ks,
  input  logic [KW-1:0]        kd,
  output logic                 out_valid,
  output logic signed [DW-1:0] lpr,
  output logic signed [DW-1:0] lmr,
  output logic                 sat_lpr,
  output logic                 sat_lmr
);

  localparam int AW = DW + KW + 1;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;

  localparam logic signed [DW-1:0] MAXD = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIND = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [AW-1:0] MAXA = {{(AW-DW){1'b0}}, MAXD};
  localparam logic signed [AW-1:0] MINA = {{(AW-DW){1'b1}}, MIND};
  // Half an output LSB, added before the floor shift to round toward +inf.
  localparam logic signed [AW-1:0] RND =
    (ROUND != 0 && FRAC > 0) ? (AW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;

  typedef enum logic [1:0] {IDLE, MIX, MULT, SCALE} state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic signed [DW-1:0]  left_q, left_d, right_q, right_d;
  logic [KW-1:0]         ks_q, ks_d, kd_q, kd_d;
  logic signed [DW-1:0]  mix_s_q, mix_s_d, mix_d_q, mix_d_d;
  logic                  msat_s_q, msat_s_d, msat_d_q, msat_d_d;
  logic signed [AW-1:0]  acc_s_q, acc_s_d, acc_d_q, acc_d_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [DW-1:0]  lpr_q, lpr_d, lmr_q, lmr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sat_lpr_q, sat_lpr_d, sat_lmr_q, sat_lmr_d;

  logic signed [DW:0]    sum_w, dif_w;
  logic signed [AW-1:0]  mix_s_ext, mix_d_ext;
  logic signed [AW-1:0]  rnd_s, rnd_d, shf_s, shf_d;

  function automatic logic [DW:0] mix_sat(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1]) return {1'b1, (v[DW] ? MIND : MAXD)};
    return {1'b0, v[DW-1:0]};
  endfunction

  function automatic logic [DW:0] out_sat(input logic signed [AW-1:0] v);
    if (v > MAXA) return {1'b1, MAXD};
    if (v < MINA) return {1'b1, MIND};
    return {1'b0, v[DW-1:0]};
  endfunction

  assign sum_w     = {left_q[DW-1], left_q} + {right_q[DW-1], right_q};
  assign dif_w     = {left_q[DW-1], left_q} - {right_q[DW-1], right_q};
  assign mix_s_ext = {{(AW-DW){mix_s_q[DW-1]}}, mix_s_q};
  assign mix_d_ext = {{(AW-DW){mix_d_q[DW-1]}}, mix_d_q};
  assign rnd_s     = acc_s_q + RND;
  assign rnd_d     = acc_d_q + RND;
  assign shf_s     = rnd_s >>> FRAC;
  assign shf_d     = rnd_d >>> FRAC;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    left_d      = left_q;
    right_d     = right_q;
    ks_d        = ks_q;
    kd_d        = kd_q;
    mix_s_d     = mix_s_q;
    mix_d_d     = mix_d_q;
    msat_s_d    = msat_s_q;
    msat_d_d    = msat_d_q;
    acc_s_d     = acc_s_q;
    acc_d_d     = acc_d_q;
    cnt_d       = cnt_q;
    lpr_d       = lpr_q;
    lmr_d       = lmr_q;
    out_valid_d = 1'b0;
    sat_lpr_d   = sat_lpr_q;
    sat_lmr_d   = sat_lmr_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          left_d     = left;
          right_d    = right;
          ks_d       = ks;
          kd_d       = kd;
          in_ready_d = 1'b0;
          state_d    = MIX;
        end
      end
      MIX: begin
        {msat_s_d, mix_s_d} = mix_sat(sum_w);
        {msat_d_d, mix_d_d} = mix_sat(dif_w);
        acc_s_d = '0;
        acc_d_d = '0;
        cnt_d   = '0;
        state_d = MULT;
      end
      MULT: begin
        // One gain bit per cycle, LSB first.
        acc_s_d = acc_s_q + (ks_q[cnt_q] ? (mix_s_ext <<< cnt_q) : '0);
        acc_d_d = acc_d_q + (kd_q[cnt_q] ? (mix_d_ext <<< cnt_q) : '0);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(KW - 1)) state_d = SCALE;
      end
      SCALE: begin
        {sat_lpr_d, lpr_d} = out_sat(shf_s);
        {sat_lmr_d, lmr_d} = out_sat(shf_d);
        sat_lpr_d   = sat_lpr_d | msat_s_q;
        sat_lmr_d   = sat_lmr_d | msat_d_q;
        out_valid_d = 1'b1;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      left_q      <= '0;
      right_q     <= '0;
      ks_q        <= '0;
      kd_q        <= '0;
      mix_s_q     <= '0;
      mix_d_q     <= '0;
      msat_s_q    <= 1'b0;
      msat_d_q    <= 1'b0;
      acc_s_q     <= '0;
      acc_d_q     <= '0;
      cnt_q       <= '0;
      lpr_q       <= '0;
      lmr_q       <= '0;
      out_valid_q <= 1'b0;
      sat_lpr_q   <= 1'b0;
      sat_lmr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      left_q      <= left_d;
      right_q     <= right_d;
      ks_q        <= ks_d;
      kd_q        <= kd_d;
      mix_s_q     <= mix_s_d;
      mix_d_q     <= mix_d_d;
      msat_s_q    <= msat_s_d;
      msat_d_q    <= msat_d_d;
      acc_s_q     <= acc_s_d;
      acc_d_q     <= acc_d_d;
      cnt_q       <= cnt_d;
      lpr_q       <= lpr_d;
      lmr_q       <= lmr_d;
      out_valid_q <= out_valid_d;
      sat_lpr_q   <= sat_lpr_d;
      sat_lmr_q   <= sat_lmr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign lpr       = lpr_q;
  assign lmr       = lmr_q;
  assign sat_lpr   = sat_lpr_q;
  assign sat_lmr   = sat_lmr_q;

endmodule

// File: tb/tb_stereo_matrix_gain.sv
// Bench for stereo_matrix_gain: rounding and truncating instances share
// stimulus; expected results are queued at accept and checked at out_valid.
module tb_stereo_matrix_gain;
  localparam int DW = 18;
  localparam int KW = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] left = '0, right = '0;
  logic [KW-1:0]        ks = '0, kd = '0;

  logic                 in_ready, out_valid, sat_lpr, sat_lmr;
  logic signed [DW-1:0] lpr, lmr;
  logic                 in_ready_t, out_valid_t, sat_lpr_t, sat_lmr_t;
  logic signed [DW-1:0] lpr_t, lmr_t;

  stereo_matrix_gain #(.DW(DW), .KW(KW), .FRAC(3), .ROUND(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .left(left), .right(right), .ks(ks), .kd(kd), .out_valid(out_valid),
    .lpr(lpr), .lmr(lmr), .sat_lpr(sat_lpr), .sat_lmr(sat_lmr));

  stereo_matrix_gain #(.DW(DW), .KW(KW), .FRAC(3), .ROUND(0)) dut_t (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
    .left(left), .right(right), .ks(ks), .kd(kd), .out_valid(out_valid_t),
    .lpr(lpr_t), .lmr(lmr_t), .sat_lpr(sat_lpr_t), .sat_lmr(sat_lmr_t));

  always #5 clock = ~clock;

  typedef struct {
    logic signed [DW-1:0] l, r;
    logic [KW-1:0]        ks, kd;
    logic signed [DW-1:0] lpr, lmr;     // ROUND=1
    logic signed [DW-1:0] lpr_t, lmr_t; // ROUND=0
    logic                 sl, sd;
  } vec_t;

  typedef struct {
    vec_t v;
    int   cyc;
    int   idx;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic vec_t mk(int l, int r, int ks_, int kd_, int lp, int lm,
                              int lpt, int lmt, int sl, int sd);
    vec_t v;
    v.l = DW'(l);  v.r = DW'(r);
    v.ks = KW'(ks_); v.kd = KW'(kd_);
    v.lpr = DW'(lp); v.lmr = DW'(lm);
    v.lpr_t = DW'(lpt); v.lmr_t = DW'(lmt);
    v.sl = 1'(sl); v.sd = 1'(sd);
    return v;
  endfunction

  task automatic check(string name, int got, int want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Output monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_latency", e.idx), cyc - e.cyc, 7);
        check($sformatf("v%0d_lpr", e.idx), lpr, e.v.lpr);
        check($sformatf("v%0d_lmr", e.idx), lmr, e.v.lmr);
        check($sformatf("v%0d_sat_lpr", e.idx), sat_lpr, e.v.sl);
        check($sformatf("v%0d_sat_lmr", e.idx), sat_lmr, e.v.sd);
        check($sformatf("v%0d_trunc_valid", e.idx), out_valid_t, 1);
        check($sformatf("v%0d_trunc_lpr", e.idx), lpr_t, e.v.lpr_t);
        check($sformatf("v%0d_trunc_lmr", e.idx), lmr_t, e.v.lmr_t);
        check($sformatf("v%0d_trunc_sat_lpr", e.idx), sat_lpr_t, e.v.sl);
        check($sformatf("v%0d_trunc_sat_lmr", e.idx), sat_lmr_t, e.v.sd);
      end
    end
  end

  // Drive a pair and hold in_valid until accepted; returns after the accept edge.
  task automatic send(input vec_t v, input int idx, input bit push, output int acc_cyc);
    int b;
    @(negedge clock);
    left = v.l; right = v.r; ks = v.ks; kd = v.kd;
    in_valid = 1'b1;
    b = 0;
    while (!in_ready && b < 50) begin
      @(negedge clock);
      b++;
    end
    acc_cyc = cyc;
    if (!in_ready) begin
      check($sformatf("v%0d_accept_timeout", idx), 0, 1);
    end else begin
      if (push) sb.push_back('{v: v, cyc: cyc, idx: idx});
      @(posedge clock);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev, b;
    bit seen;
    vecs[0] = mk(1000, 200, 8, 8, 1200, 800, 1200, 800, 0, 0);
    vecs[1] = mk(100000, 100000, 8, 8, 131071, 0, 131071, 0, 1, 0);
    vecs[2] = mk(-100000, 100000, 8, 15, 0, -131072, 0, -131072, 0, 1);
    vecs[3] = mk(-4, 0, 1, 0, 0, 0, -1, 0, 0, 0);
    vecs[4] = mk(3, 0, 3, 3, 1, 1, 1, 1, 0, 0);
    vecs[5] = mk(5000, -7000, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(100000, 0, 15, 4, 131071, 50000, 131071, 50000, 1, 0);
    vecs[7] = mk(-10, -3, 5, 7, -8, -6, -9, -7, 0, 0);
    vecs[8] = mk(131071, -131072, 8, 1, -1, 16384, -1, 16383, 0, 1);
    vecs[9] = mk(4, 0, 1, 15, 1, 8, 0, 7, 0, 0);

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_lpr", lpr, 0);
    check("rst_lmr", lmr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sat", {sat_lpr, sat_lmr}, 0);
    reset = 1'b0;

    // Single pair: in_ready low T+1..T+6, out_valid only at T+7
    send(vecs[0], 0, 1'b1, acc);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      in_valid = 1'b0;
      check($sformatf("busy_in_ready_T+%0d", i), in_ready, 0);
      check($sformatf("busy_out_valid_T+%0d", i), out_valid, 0);
    end
    @(negedge clock);
    check("done_out_valid_T+7", out_valid, 1);
    check("done_in_ready_T+7", in_ready, 1);
    @(negedge clock);
    check("pulse_out_valid_T+8", out_valid, 0);

    // Reset during MULT aborts the sample
    send(vecs[6], 100, 1'b0, acc);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_lpr_cleared", lpr, 0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", seen, 0);

    // Back-to-back table with in_valid held high
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i], i, 1'b1, acc);
      if (i > 0) check($sformatf("v%0d_spacing", i), acc - prev, 7);
      prev = acc;
    end
    @(negedge clock);
    in_valid = 1'b0;

    b = 0;
    while (sb.size() > 0 && b < 50) begin
      @(negedge clock);
      b++;
    end
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
